// File: rtl/fibonacci_sequencer.sv
// Iterative Fibonacci engine: start/accept in IDLE, one add per cycle in RUN,
// result held in DONE until acknowledged. Overflow tracks the true (unwrapped) magnitude.
module fibonacci_sequencer #(
    parameter int WIDTH = 8,
    parameter int N_W   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N_W-1:0]   n,
    input  logic             abort,
    output logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             result_valid,
    input  logic             result_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] cur;
    logic [N_W-1:0]   count;
    logic             prev_ovf;
    logic             cur_ovf;
    logic [WIDTH:0]   sum;

    // Plain WIDTH-bit add, carry-in 0; the extra MSB is the carry-out.
    function automatic logic [WIDTH:0] add_carry(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    assign sum = add_carry(prev, cur);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            prev     <= '0;
            cur      <= WIDTH'(1);
            count    <= '0;
            prev_ovf <= 1'b0;
            cur_ovf  <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        prev     <= '0;
                        cur      <= WIDTH'(1);
                        count    <= n;
                        prev_ovf <= 1'b0;
                        cur_ovf  <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (count == '0) begin
                        // prev holds F(n); cur may already have wrapped, which must not leak into overflow.
                        state    <= DONE;
                        result   <= prev;
                        overflow <= prev_ovf;
                    end else begin
                        prev     <= cur;
                        cur      <= sum[WIDTH-1:0];
                        prev_ovf <= cur_ovf;
                        cur_ovf  <= cur_ovf | sum[WIDTH];
                        count    <= count - 1'b1;
                    end
                end
                DONE: begin
                    if (result_ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready        = (state == IDLE);
    assign busy         = (state == RUN);
    assign result_valid = (state == DONE);

endmodule

// File: tb/tb_fibonacci_sequencer.sv
// Bench for fibonacci_sequencer: directed scenarios plus random indices,
// checked against a wide-integer Fibonacci model.
module tb_fibonacci_sequencer;

    localparam int WIDTH = 8;
    localparam int N_W   = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [N_W-1:0]   n = '0;
    logic             abort = 1'b0;
    logic             ready;
    logic             busy;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             result_valid;
    logic             result_ack = 1'b0;

    int checks = 0;
    int fails  = 0;

    fibonacci_sequencer #(.WIDTH(WIDTH), .N_W(N_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .n            (n),
        .abort        (abort),
        .ready        (ready),
        .busy         (busy),
        .result       (result),
        .overflow     (overflow),
        .result_valid (result_valid),
        .result_ack   (result_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: true Fibonacci value in a wide integer, then reduced.
    task automatic fib_ref(input int k, output logic [WIDTH-1:0] r, output logic ovf);
        longint a = 0;
        longint b = 1;
        longint t;
        for (int i = 0; i < k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        r   = WIDTH'(a % (longint'(1) << WIDTH));
        ovf = (a >= (longint'(1) << WIDTH));
    endtask

    // Called at a negedge with the DUT idle; leaves the DUT idle at a negedge.
    task automatic run_fib(input int k, input string tag);
        logic [WIDTH-1:0] er;
        logic             eo;
        int               lat;
        fib_ref(k, er, eo);
        check({tag, "_ready_before"}, 32'(ready), 32'd1);
        start = 1'b1;
        n     = N_W'(k);
        @(negedge clk);
        start = 1'b0;
        n     = N_W'($urandom);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (!result_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(k + 1));
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_overflow"}, 32'(overflow), 32'(eo));
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        check({tag, "_ready_after_ack"}, 32'(ready), 32'd1);
        check({tag, "_valid_after_ack"}, 32'(result_valid), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] held;
        int               saw_valid;
        int               k;

        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;

        // First start right at the first edge without reset.
        run_fib(0, "n0");
        run_fib(1, "n1");
        run_fib(2, "n2");
        run_fib(10, "n10");
        run_fib(13, "n13");
        run_fib(14, "n14");
        run_fib(31, "n31");

        // Abort and ack in IDLE are ignored.
        abort = 1'b1;
        result_ack = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        result_ack = 1'b0;
        check("idle_abort_ready", 32'(ready), 32'd1);

        // Abort four cycles into an n=10 run.
        start = 1'b1;
        n     = 5'd10;
        @(negedge clk);
        start = 1'b0;
        saw_valid = 0;
        repeat (3) begin
            @(negedge clk);
            if (result_valid) saw_valid++;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (12) begin
            @(negedge clk);
            if (result_valid) saw_valid++;
        end
        check("abort_no_valid", 32'(saw_valid), 32'd0);
        run_fib(5, "after_abort_n5");

        // Start, ack and n changes in RUN must not disturb an n=6 run.
        start = 1'b1;
        n     = 5'd6;
        @(negedge clk);
        start = 1'b1;
        result_ack = 1'b1;
        n = 5'd20;
        repeat (3) @(negedge clk);
        start = 1'b0;
        result_ack = 1'b0;
        k = 0;
        while (!result_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("run_ignore_result", 32'(result), 32'd8);
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;

        // Hold DONE for 20 cycles with start pulses.
        start = 1'b1;
        n     = 5'd7;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!result_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        held = result;
        check("hold_result", 32'(held), 32'd13);
        for (int i = 0; i < 20; i++) begin
            start = 1'($urandom);
            abort = 1'($urandom);
            n     = N_W'($urandom);
            @(negedge clk);
            check("hold_stable", {23'd0, result_valid, result}, {23'd1, 8'd13});
        end
        abort = 1'b0;
        start = 1'b1;
        result_ack = 1'b1;
        @(negedge clk);
        start = 1'b0;
        result_ack = 1'b0;
        check("start_ack_ready", 32'(ready), 32'd1);
        check("start_ack_busy", 32'(busy), 32'd0);

        // Reset in the middle of an n=20 run.
        start = 1'b1;
        n     = 5'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        result_ack = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        result_ack = 1'b0;
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(result_valid), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        run_fib(12, "after_rst_n12");

        // Random indices across the full range.
        for (int i = 0; i < 12; i++) begin
            k = int'($urandom_range(0, (1 << N_W) - 1));
            run_fib(k, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
